// File: rtl/uart_mem_loader_if.sv
// UART byte streams and word-memory ports seen by the UART memory loader.
// The master side drives the memory and UART TX request signals.
interface uart_mem_loader_if #(
    parameter int BYTE_ADDR_WIDTH = 6
);
    localparam int WA = BYTE_ADDR_WIDTH - 2;

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          mem_wr_en;
    logic [WA-1:0] mem_wr_addr;
    logic [3:0]    mem_byte_en;
    logic [31:0]   mem_wr_data;
    logic          mem_rd_en;
    logic [WA-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;

    modport master (
        input  rx_data, rx_valid, tx_busy, mem_rd_data,
        output tx_data, tx_start,
        output mem_wr_en, mem_wr_addr, mem_byte_en, mem_wr_data,
        output mem_rd_en, mem_rd_addr
    );

    modport slave (
        output rx_data, rx_valid, tx_busy, mem_rd_data,
        input  tx_data, tx_start,
        input  mem_wr_en, mem_wr_addr, mem_byte_en, mem_wr_data,
        input  mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/uart_mem_loader.sv
// UART-driven memory loader: writes words from a W frame into memory,
// or dumps words over UART TX for an R frame. Holds the CPU while busy.
module uart_mem_loader #(
    parameter int BYTE_ADDR_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_mem_loader_if.master    bus,
    output logic                 busy,
    output logic                 cpu_hold
);
    localparam int WA = BYTE_ADDR_WIDTH - 2;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [3:0] {
        IDLE, ADDR_L, ADDR_H, CNT_L, CNT_H,
        WR_DATA, RD_REQ, RD_WAIT, RD_SEND, TX_GAP
    } state_t;

    state_t        state, state_n;
    logic [15:0]   addr, addr_n;
    logic [15:0]   cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [31:0]   data, data_n;
    logic          is_wr, is_wr_n;
    logic [7:0]    tx_data_q, tx_data_n;
    logic          tx_start_q, tx_start_n;
    logic          wr_en_q, wr_en_n;
    logic [WA-1:0] wr_addr_q, wr_addr_n;
    logic [3:0]    be_q, be_n;
    logic [31:0]   wr_data_q, wr_data_n;
    logic          rd_en_q, rd_en_n;
    logic [WA-1:0] rd_addr_q, rd_addr_n;

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        cnt_n      = cnt;
        idx_n      = idx;
        data_n     = data;
        is_wr_n    = is_wr;
        tx_data_n  = tx_data_q;
        tx_start_n = 1'b0;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr_q;
        wr_data_n  = wr_data_q;
        unique case (state)
            IDLE: if (bus.rx_valid &&
                      (bus.rx_data == CMD_W || bus.rx_data == CMD_R)) begin
                is_wr_n = (bus.rx_data == CMD_W);
                state_n = ADDR_L;
            end
            ADDR_L: if (bus.rx_valid) begin
                addr_n[7:0] = bus.rx_data;
                state_n     = ADDR_H;
            end
            ADDR_H: if (bus.rx_valid) begin
                addr_n[15:8] = bus.rx_data;
                state_n      = CNT_L;
            end
            CNT_L: if (bus.rx_valid) begin
                cnt_n[7:0] = bus.rx_data;
                state_n    = CNT_H;
            end
            CNT_H: if (bus.rx_valid) begin
                cnt_n[15:8] = bus.rx_data;
                idx_n       = 2'd0;
                if (cnt_n == 16'd0)
                    state_n = IDLE;
                else
                    state_n = is_wr ? WR_DATA : RD_REQ;
            end
            WR_DATA: if (bus.rx_valid) begin
                data_n[{idx, 3'b000} +: 8] = bus.rx_data;
                idx_n = idx + 2'd1;
                // Fourth lane completes the word: write it and step on
                if (idx == 2'd3) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = addr[WA-1:0];
                    wr_data_n = data_n;
                    addr_n    = addr + 16'd1;
                    cnt_n     = cnt - 16'd1;
                    if (cnt == 16'd1)
                        state_n = IDLE;
                end
            end
            RD_REQ: state_n = RD_WAIT;
            RD_WAIT: begin
                data_n  = bus.mem_rd_data;
                idx_n   = 2'd0;
                state_n = RD_SEND;
            end
            RD_SEND: if (!bus.tx_busy) begin
                tx_start_n = 1'b1;
                tx_data_n  = data[{idx, 3'b000} +: 8];
                state_n    = TX_GAP;
            end
            TX_GAP: begin
                // TX raises busy only after this cycle, so skip sampling it
                if (idx != 2'd3) begin
                    idx_n   = idx + 2'd1;
                    state_n = RD_SEND;
                end else begin
                    addr_n  = addr + 16'd1;
                    cnt_n   = cnt - 16'd1;
                    state_n = (cnt == 16'd1) ? IDLE : RD_REQ;
                end
            end
            default: state_n = IDLE;
        endcase
        rd_en_n   = (state_n == RD_REQ);
        rd_addr_n = rd_en_n ? addr_n[WA-1:0] : rd_addr_q;
        be_n      = wr_en_n ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            cnt        <= '0;
            idx        <= '0;
            data       <= '0;
            is_wr      <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            be_q       <= '0;
            wr_data_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            data       <= data_n;
            is_wr      <= is_wr_n;
            tx_data_q  <= tx_data_n;
            tx_start_q <= tx_start_n;
            wr_en_q    <= wr_en_n;
            wr_addr_q  <= wr_addr_n;
            be_q       <= be_n;
            wr_data_q  <= wr_data_n;
            rd_en_q    <= rd_en_n;
            rd_addr_q  <= rd_addr_n;
            busy       <= (state_n != IDLE);
            cpu_hold   <= (state_n != IDLE);
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_byte_en = be_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_rd_addr = rd_addr_q;
endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: frame-level memory/TX reference model,
// directed frames followed by randomized write/read frames.
module tb_uart_mem_loader;
    localparam int BAW = 6;
    localparam int WA  = BAW - 2;
    localparam int NW  = 1 << WA;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic cpu_hold;

    uart_mem_loader_if #(.BYTE_ADDR_WIDTH(BAW)) bus ();

    uart_mem_loader #(.BYTE_ADDR_WIDTH(BAW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master),
        .busy     (busy),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    // UART TX stand-in: busy from the cycle after tx_start
    int tx_left = 0;
    always @(posedge clk) begin
        if (bus.tx_start)
            tx_left <= int'($urandom_range(6, 1));
        else if (tx_left > 0)
            tx_left <= tx_left - 1;
    end
    assign bus.tx_busy = (tx_left != 0);

    // Memory stand-in with registered read data
    logic [31:0] dev_mem [NW];
    always @(posedge clk) begin
        if (bus.mem_wr_en)
            dev_mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        if (bus.mem_rd_en)
            bus.mem_rd_data <= dev_mem[bus.mem_rd_addr];
    end

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
        logic        busy;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];
    int cyc = 0;
    int n_rd = 0;
    int bad_both = 0;
    int bad_tx = 0;
    int bad_hold = 0;
    int bad_be = 0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.mem_wr_en === 1'b1) begin
            wr_q.push_back('{int'(bus.mem_wr_addr), bus.mem_wr_data,
                             cyc, busy});
            if (bus.mem_byte_en !== 4'hF) bad_be++;
        end
        if (bus.mem_rd_en === 1'b1) n_rd++;
        if (bus.mem_wr_en === 1'b1 && bus.mem_rd_en === 1'b1) bad_both++;
        if (bus.tx_start === 1'b1) begin
            tx_q.push_back(bus.tx_data);
            if (bus.tx_busy !== 1'b0) bad_tx++;
        end
        if (cpu_hold !== busy) bad_hold++;
    end

    int n_chk = 0;
    int n_fail = 0;
    int last_cyc = 0;
    int mid_drop = 0;
    logic [31:0] model [NW];
    logic [31:0] none[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        last_cyc     = cyc;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input int a16,
                              input int c16, input logic [31:0] words[$],
                              input int maxgap);
        logic [7:0] bq[$];
        logic [31:0] w;
        bq = {cmd, a16[7:0], a16[15:8], c16[7:0], c16[15:8]};
        foreach (words[i]) begin
            w = words[i];
            for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
        end
        foreach (bq[i]) begin
            send(bq[i]);
            if (i != bq.size() - 1) begin
                if (busy !== 1'b1 || cpu_hold !== 1'b1) mid_drop++;
                idle(int'($urandom_range(maxgap, 0)));
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_write(input string tag, input int a16,
                            input logic [31:0] words[$], input int maxgap);
        int ea;
        wr_q.delete();
        send_frame(8'h57, a16, words.size(), words, maxgap);
        wait_idle(tag);
        check({tag, "_nwr"}, wr_q.size(), words.size());
        foreach (words[i]) begin
            ea = (a16 + i) % NW;
            model[ea] = words[i];
            if (i < wr_q.size()) begin
                check({tag, "_addr"}, wr_q[i].addr, ea);
                check({tag, "_data"}, wr_q[i].data, words[i]);
                check({tag, "_busy"}, {31'd0, wr_q[i].busy},
                      (i == words.size() - 1) ? 32'd0 : 32'd1);
            end
        end
    endtask

    task automatic do_read(input string tag, input int a16, input int n,
                           input bit stray, input int maxgap);
        int rd0;
        logic [31:0] w;
        tx_q.delete();
        wr_q.delete();
        rd0 = n_rd;
        send_frame(8'h52, a16, n, none, maxgap);
        if (stray) begin
            idle(2);
            send(8'h57);
            send(8'h00);
        end
        wait_idle(tag);
        check({tag, "_ntx"}, tx_q.size(), 4 * n);
        for (int i = 0; i < 4 * n && i < tx_q.size(); i++) begin
            w = model[(a16 + i / 4) % NW];
            check({tag, "_byte"}, {24'd0, tx_q[i]},
                  {24'd0, w[8*(i%4) +: 8]});
        end
        check({tag, "_nowr"}, wr_q.size(), 0);
        check({tag, "_nrd"}, n_rd - rd0, n);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wdata"}, bus.mem_wr_data, 32'd0);
        check({tag, "_outs"},
              {7'd0, bus.tx_data, bus.tx_start, bus.mem_wr_en,
               bus.mem_wr_addr, bus.mem_byte_en, bus.mem_rd_en,
               bus.mem_rd_addr, busy, cpu_hold}, 32'd0);
    endtask

    initial begin
        int rd0;
        int a;
        int n;
        logic [31:0] ws[$];

        rst          = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        idle(2);
        check_zero("reset0");
        rst = 1'b0;
        idle(2);

        // single write
        do_write("single", 3, '{32'hDEADBEEF}, 2);
        check("single_hold", mid_drop, 0);

        // reset in WR_DATA after two payload bytes
        wr_q.delete();
        send_frame(8'h57, 1, 1, none, 1);
        send(8'hAA);
        send(8'hBB);
        rst = 1'b1;
        idle(1);
        check_zero("reset_mid");
        idle(1);
        rst = 1'b0;
        idle(4);
        check("reset_nowr", wr_q.size(), 0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // wrapping write
        do_write("wrap", 16'h000F, '{32'h44332211, 32'h88776655}, 1);

        // read dump with stray bytes
        do_write("pre", 5, '{32'hCAFEF00D, 32'h01234567}, 0);
        do_read("dump", 5, 2, 1'b1, 1);
        check("dump_b0", {24'd0, tx_q[0]}, 32'h0D);
        check("dump_b7", {24'd0, tx_q[7]}, 32'h01);

        // zero count and bad command
        wr_q.delete();
        tx_q.delete();
        rd0 = n_rd;
        send_frame(8'h57, 0, 0, none, 0);
        check("zero_w_idle", {31'd0, busy}, 32'd0);
        send(8'h41);
        idle(1);
        check("bad_idle", {31'd0, busy}, 32'd0);
        send_frame(8'h52, 0, 0, none, 0);
        check("zero_r_idle", {31'd0, busy}, 32'd0);
        idle(10);
        check("zero_nowr", wr_q.size(), 0);
        check("zero_notx", tx_q.size(), 0);
        check("zero_nord", n_rd - rd0, 0);

        // back-to-back bytes
        do_write("b2b", 9, '{32'h0A0B0C0D}, 0);
        if (wr_q.size() > 0)
            check("b2b_lat", wr_q[0].cyc, last_cyc + 1);

        // fill everything, then random frames
        ws.delete();
        for (int i = 0; i < NW; i++) ws.push_back($urandom);
        do_write("fill", 0, ws, 1);
        for (int t = 0; t < 10; t++) begin
            a = int'($urandom_range(16'hFFFF, 0));
            n = int'($urandom_range(3, 1));
            if ($urandom_range(1, 0) == 1) begin
                ws.delete();
                for (int i = 0; i < n; i++) ws.push_back($urandom);
                do_write("rnd_wr", a, ws, 2);
            end else begin
                do_read("rnd_rd", a, n, 1'b0, 2);
            end
        end

        check("both_strobes", bad_both, 0);
        check("tx_while_busy", bad_tx, 0);
        check("hold_eq_busy", bad_hold, 0);
        check("byte_en", bad_be, 0);
        check("frame_hold", mid_drop, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Bus initiator that drives the byte-addressed word memory's write channel and one read channel from a UART byte stream.
- Used to load program words into instruction or data memory and to dump memory contents back out over UART TX.
- Sits between the UART RX/TX byte interfaces and the memory ports.
- Holds the CPU in reset while a transfer is in progress.

Parameters:
- BYTE_ADDR_WIDTH, 6, byte-level address width of the target memory. The word address width is BYTE_ADDR_WIDTH-2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from UART RX
- rx_valid  in  1  one-cycle pulse; rx_data is valid this cycle
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data
- tx_busy  in  1  UART TX is transmitting; asserted by TX from the cycle after tx_start
- mem_wr_en  out  1  memory write strobe
- mem_wr_addr  out  BYTE_ADDR_WIDTH-2  word write address
- mem_byte_en  out  4  byte enables; always 4'hF when mem_wr_en=1
- mem_wr_data  out  32  write data
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  BYTE_ADDR_WIDTH-2  word read address
- mem_rd_data  in  32  registered read data, valid 1 cycle after mem_rd_en
- busy  out  1  high in any state other than IDLE
- cpu_hold  out  1  equals busy; keeps the CPU in reset during a transfer

Behaviour:
- Clocking and reset:
  - All outputs are registered.
  - On rst: state=IDLE; all strobes, tx_data, mem_* addresses and data, and the internal address/count/assembly registers are 0; busy=0 and cpu_hold=0.
  - rst mid-transfer aborts immediately. Any partially assembled word is discarded and no write is issued.
- Frame format (all multi-byte fields little-endian):
  - CMD(1 byte), ADDR(2 bytes, word address), COUNT(2 bytes, number of words), then payload.
  - CMD 0x57 ('W') is a write. The payload is 4*COUNT bytes, each word LSB first.
  - CMD 0x52 ('R') is a read. There is no payload; the block transmits 4*COUNT bytes, LSB first.
  - Any other CMD byte is ignored and the block stays in IDLE.
- ADDR handling:
  - Only the low BYTE_ADDR_WIDTH-2 bits of ADDR are used.
  - The address increments by 1 per word and wraps modulo 2^(BYTE_ADDR_WIDTH-2).
- State machine:
  - IDLE -> ADDR_L -> ADDR_H -> CNT_L -> CNT_H.
  - From CNT_H: if COUNT==0, go to IDLE. Otherwise go to WR_DATA for 'W' or RD_REQ for 'R'.
  - Each of these states advances only on rx_valid.
- WR_DATA:
  - A 2-bit byte index selects the lane; rx_data is stored into lane [8*idx +: 8].
  - On the 4th byte (idx==3), in the next cycle: mem_wr_en=1 for exactly 1 cycle, mem_wr_addr=current address, mem_wr_data=assembled word, mem_byte_en=4'hF.
  - After that write, address++ and remaining--. When remaining reaches 0, return to IDLE in that same cycle.
  - No stall state; back-to-back rx_valid on consecutive cycles must still be handled.
- RD_REQ: mem_rd_en=1 for 1 cycle with mem_rd_addr=current address, then go to RD_WAIT.
- RD_WAIT: capture mem_rd_data into a shift register, set byte index=0, go to RD_SEND.
- RD_SEND:
  - Wait until tx_busy==0. Then pulse tx_start for 1 cycle with tx_data=byte[idx] and go to TX_GAP.
- TX_GAP:
  - Lasts 1 cycle; tx_busy is not sampled here.
  - If idx<3: idx++ and go back to RD_SEND.
  - If idx==3: address++, remaining--, then go to RD_REQ, or to IDLE if remaining==0.
- rx_valid is ignored in all read states; bytes arriving during a dump are dropped.
- mem_wr_en and mem_rd_en are never asserted in the same cycle.
- Strobes are 0 whenever they are not explicitly pulsed.

Test Plan:
- Reset: assert rst for 2 cycles while in WR_DATA with 2 bytes received. Required: all outputs 0, busy=0, and no mem_wr_en before or after reset.
- Single write: send 57 03 00 01 00 EF BE AD DE. Required: exactly one mem_wr_en with addr=3, data=32'hDEADBEEF, byte_en=F; busy falls in the same cycle; cpu_hold high throughout.
- Wrapping write (BYTE_ADDR_WIDTH=6): send 57 0F 00 02 00 followed by 8 bytes 11 22 33 44 55 66 77 88. Required: writes to addr 15 with data 32'h44332211, then addr 0 with data 32'h88776655.
- Read dump: model the memory with word 5=32'hCAFEF00D and word 6=32'h01234567, then send 52 05 00 02 00. Required: transmitted sequence 0D F0 FE CA 67 45 23 01; each tx_start occurs only while tx_busy=0; stray rx bytes during the dump cause no writes.
- Zero count and bad command: send 57 00 00 00 00, then 41, then 52 00 00 00 00. Required: no memory strobes, no tx_start, and the block returns to IDLE after each frame.
- Back-to-back rx_valid on consecutive cycles for a 1-word write of 32'h0A0B0C0D. Required: correct data is written, with mem_wr_en exactly 1 cycle after the 4th byte.
